// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI slave register file with command decode, auto-increment bursts and sticky error flag
module spi_reg_ctrl #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] SIG = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sel_n,
  input  logic               rx_valid,
  input  logic [WIDTH-1:0]   rx_data,
  output logic [WIDTH-1:0]   tx_data,
  output logic               tx_load,
  input  logic [6:0]         status_in,
  output logic [7*WIDTH-1:0] regs_out,
  output logic               wr_strobe,
  output logic [2:0]         wr_addr,
  output logic               err
);
  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DRAIN} state_t;
  state_t               state_q;
  logic [2:0]           addr_q;
  logic [2:0]           rd_addr;
  logic [6:0][WIDTH-1:0] regs_q;
  logic [WIDTH-1:0]     tx_data_q;
  logic [WIDTH-1:0]     rd_val;
  logic                 tx_load_q;
  logic                 wr_strobe_q;
  logic [2:0]           wr_addr_q;
  logic                 err_q;
  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign err       = err_q;
  assign regs_out  = regs_q;
  // next transmit value: the command's start address in CMD, otherwise the incremented burst address
  always_comb begin
    rd_addr = state_q == CMD ? rx_data[2:0] : addr_q + 3'd1;
    rd_val  = rd_addr == 3'd7 ? WIDTH'({err_q, status_in}) : regs_q[rd_addr];
  end
  // protocol FSM; deselect dominates every state and any coincident rx_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      regs_q      <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      if (sel_n) begin
        state_q <= IDLE;
        addr_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q   <= CMD;
            tx_data_q <= SIG;
            tx_load_q <= 1'b1;
          end
          CMD: if (rx_valid) begin
            if (rx_data[6:3] != 4'd0) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end else begin
              addr_q  <= rx_data[2:0];
              state_q <= rx_data[7] ? READ : WRITE;
              if (rx_data[7]) begin
                tx_data_q <= rd_val;
                tx_load_q <= 1'b1;
                if (rd_addr == 3'd7) err_q <= 1'b0;
              end
            end
          end
          WRITE: if (rx_valid) begin
            addr_q <= addr_q + 3'd1;
            if (addr_q == 3'd7) err_q <= 1'b1;
            else begin
              regs_q[addr_q] <= rx_data;
              wr_strobe_q    <= 1'b1;
              wr_addr_q      <= addr_q;
            end
          end
          READ: if (rx_valid) begin
            addr_q    <= rd_addr;
            tx_data_q <= rd_val;
            tx_load_q <= 1'b1;
            if (rd_addr == 3'd7) err_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, sel_n, rx_valid;
  logic [7:0]  rx_data, tx_data;
  logic        tx_load, wr_strobe, err;
  logic [6:0]  status_in;
  logic [55:0] regs_out, exp_regs;
  logic [2:0]  wr_addr;
  int tests = 0;
  int fails = 0;

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sel_n(sel_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_load(tx_load), .status_in(status_in), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic deselect();
    sel_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
    tests++; if (tx_load !== 1'b0) begin fails++; $display("FAIL rst_tx_load got %b exp 0", tx_load); end
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL rst_wr_strobe got %b exp 0", wr_strobe); end
    tests++; if (wr_addr !== 3'd0) begin fails++; $display("FAIL rst_wr_addr got %0d exp 0", wr_addr); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err); end
    tests++; if (regs_out !== 56'h0) begin fails++; $display("FAIL rst_regs got %h exp 0", regs_out); end
    rst_n = 1'b1;
    step();
    tests++; if (tx_load !== 1'b0) begin fails++; $display("FAIL idle_no_load got %b exp 0", tx_load); end
  endtask

  task automatic test_write_burst();
    sel_n = 1'b0;
    step();
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin fails++; $display("FAIL wb_sig load=%b data=%h exp 1/a5", tx_load, tx_data); end
    step();
    tests++; if (tx_load !== 1'b0) begin fails++; $display("FAIL wb_load_pulse got %b exp 0", tx_load); end
    send(8'h02);
    tests++; if (wr_strobe !== 1'b0 || tx_load !== 1'b0) begin fails++; $display("FAIL wb_cmd strobe=%b load=%b exp 0/0", wr_strobe, tx_load); end
    send(8'h11);
    exp_regs[2*8 +: 8] = 8'h11;
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd2) begin fails++; $display("FAIL wb_b0 strobe=%b addr=%0d exp 1/2", wr_strobe, wr_addr); end
    tests++; if (tx_load !== 1'b0) begin fails++; $display("FAIL wb_b0_noload got %b exp 0", tx_load); end
    send(8'h22);
    exp_regs[3*8 +: 8] = 8'h22;
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd3) begin fails++; $display("FAIL wb_b1 strobe=%b addr=%0d exp 1/3", wr_strobe, wr_addr); end
    send(8'h33);
    exp_regs[4*8 +: 8] = 8'h33;
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd4) begin fails++; $display("FAIL wb_b2 strobe=%b addr=%0d exp 1/4", wr_strobe, wr_addr); end
    tests++; if (regs_out !== exp_regs) begin fails++; $display("FAIL wb_regs got %h exp %h", regs_out, exp_regs); end
    step();
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL wb_strobe_pulse got %b exp 0", wr_strobe); end
    deselect();
  endtask

  task automatic test_read_wrap();
    sel_n = 1'b0;
    step();
    send(8'h06);
    send(8'h5A);
    exp_regs[6*8 +: 8] = 8'h5A;
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd6) begin fails++; $display("FAIL rw_setup strobe=%b addr=%0d exp 1/6", wr_strobe, wr_addr); end
    deselect();
    status_in = 7'h15;
    sel_n = 1'b0;
    step();
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin fails++; $display("FAIL rw_sig load=%b data=%h exp 1/a5", tx_load, tx_data); end
    send(8'h86);
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'h5A) begin fails++; $display("FAIL rw_a6 load=%b data=%h exp 1/5a", tx_load, tx_data); end
    send(8'hFF);
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'h15) begin fails++; $display("FAIL rw_a7 load=%b data=%h exp 1/15", tx_load, tx_data); end
    send(8'hFF);
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'h00) begin fails++; $display("FAIL rw_a0 load=%b data=%h exp 1/00", tx_load, tx_data); end
    tests++; if (wr_strobe !== 1'b0 || regs_out !== exp_regs) begin fails++; $display("FAIL rw_noside strobe=%b regs=%h exp 0/%h", wr_strobe, regs_out, exp_regs); end
    step();
    tests++; if (tx_load !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL rw_hold load=%b data=%h exp 0/00", tx_load, tx_data); end
    deselect();
  endtask

  task automatic test_error();
    sel_n = 1'b0;
    step();
    send(8'h48);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_set got %b exp 1", err); end
    send(8'h01);
    send(8'h55);
    tests++; if (wr_strobe !== 1'b0 || tx_load !== 1'b0 || regs_out !== exp_regs) begin fails++; $display("FAIL er_drain strobe=%b load=%b regs=%h", wr_strobe, tx_load, regs_out); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_sticky got %b exp 1", err); end
    deselect();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL er_desel got %b exp 1", err); end
    sel_n = 1'b0;
    step();
    send(8'h87);
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'h95) begin fails++; $display("FAIL er_read7 load=%b data=%h exp 1/95", tx_load, tx_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL er_clear got %b exp 0", err); end
    deselect();
  endtask

  task automatic test_ro_write();
    sel_n = 1'b0;
    step();
    send(8'h07);
    send(8'hFF);
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL ro_strobe got %b exp 0", wr_strobe); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL ro_err got %b exp 1", err); end
    tests++; if (regs_out !== exp_regs) begin fails++; $display("FAIL ro_regs got %h exp %h", regs_out, exp_regs); end
    deselect();
  endtask

  task automatic test_abort();
    sel_n = 1'b0;
    step();
    send(8'h00);
    send(8'h77);
    exp_regs[0 +: 8] = 8'h77;
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd0) begin fails++; $display("FAIL ab_b0 strobe=%b addr=%0d exp 1/0", wr_strobe, wr_addr); end
    sel_n = 1'b1;
    send(8'h88);
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL ab_strobe got %b exp 0", wr_strobe); end
    tests++; if (regs_out !== exp_regs) begin fails++; $display("FAIL ab_regs got %h exp %h", regs_out, exp_regs); end
    sel_n = 1'b0;
    step();
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin fails++; $display("FAIL ab_idle load=%b data=%h exp 1/a5", tx_load, tx_data); end
    deselect();
  endtask

  task automatic test_reset_mid_write();
    sel_n = 1'b0;
    step();
    send(8'h03);
    send(8'h44);
    tests++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd3) begin fails++; $display("FAIL rm_b0 strobe=%b addr=%0d exp 1/3", wr_strobe, wr_addr); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_regs = '0;
    tests++; if (regs_out !== exp_regs || tx_data !== 8'h00 || tx_load !== 1'b0) begin fails++; $display("FAIL rm_data regs=%h tx=%h load=%b exp 0", regs_out, tx_data, tx_load); end
    tests++; if (wr_strobe !== 1'b0 || wr_addr !== 3'd0 || err !== 1'b0) begin fails++; $display("FAIL rm_ctl strobe=%b addr=%0d err=%b exp 0", wr_strobe, wr_addr, err); end
    step();
    tests++; if (tx_load !== 1'b1 || tx_data !== 8'hA5) begin fails++; $display("FAIL rm_restart load=%b data=%h exp 1/a5", tx_load, tx_data); end
    deselect();
  endtask

  initial begin
    rst_n = 1'b0;
    sel_n = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    status_in = 7'h00;
    exp_regs = '0;
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_error();
    test_ro_write();
    test_abort();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
